fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter sharing one synchronous FIFO's write port (data_in/wr_en/full) among NUM_REQ producers. Each producer uses a valid/ready handshake. The winner holds the port for a burst of up to MAX_BURST words, then the grant rotates. Sits directly in front of the sync FIFO; the FIFO's read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 97 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Shared write-port bundle between NUM_REQ producers, the round-robin arbiter and the FIFO write side.
// The arbiter takes the slave view; the producers, the FIFO and any observer take the master view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          grant_active;
  logic [GW-1:0]                 grant_id;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_active, grant_id
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_active, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: one owner at a time writes bursts of up to MAX_BURST words
// into a sync FIFO, then the grant rotates with no idle bubble between owners.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             r_state, w_state_nxt;
  logic [GW-1:0]      r_grant_id, w_grant_id_nxt;
  logic [GW-1:0]      r_rr_last, w_rr_last_nxt;
  logic [CW-1:0]      r_burst_cnt, w_burst_cnt_nxt;
  logic [GW-1:0]      w_search_base, w_pick;
  logic               w_found, w_wr, w_release;
  logic [NUM_REQ-1:0] w_ready;

  // On release the search starts after the current owner, so it is considered last.
  assign w_search_base = (r_state == GRANT) ? r_grant_id : r_rr_last;

  always_comb begin
    logic [GW-1:0] cand;
    w_found = 1'b0;
    w_pick  = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= unsigned'(NUM_REQ); k++) begin
      cand = GW'((32'(w_search_base) + k) % unsigned'(NUM_REQ));
      if (!w_found && bus.req_valid[cand]) begin
        w_found = 1'b1;
        w_pick  = cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == GRANT && !bus.fifo_full && !rst) w_ready[r_grant_id] = 1'b1;
  end

  assign w_wr             = |(w_ready & bus.req_valid);
  assign bus.req_ready    = w_ready;
  assign bus.fifo_wr_en   = w_wr;
  assign bus.fifo_data_in = (r_state == GRANT) ? bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.grant_active = (r_state == GRANT);
  assign bus.grant_id     = r_grant_id;

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_id_nxt  = r_grant_id;
    w_burst_cnt_nxt = r_burst_cnt;
    w_rr_last_nxt   = r_rr_last;
    w_release       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt     = GRANT;
          w_grant_id_nxt  = w_pick;
          w_burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        w_release = !bus.req_valid[r_grant_id] ||
                    (w_wr && r_burst_cnt == CW'(MAX_BURST - 1));
        if (w_release) begin
          w_rr_last_nxt   = r_grant_id;
          w_burst_cnt_nxt = '0;
          if (w_found) w_grant_id_nxt = w_pick;
          else         w_state_nxt    = IDLE;
        end else if (w_wr) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_rr_last   <= GW'(NUM_REQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rr_last   <= w_rr_last_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a word-counting round-robin reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0]  valid;
  logic [DW-1:0] data [N];
  logic          full;

  // Reference model: owner index (-1 = nobody), words written this burst, last released owner.
  int m_owner, m_cnt, m_last;
  int n_vec, n_err;
  logic         obs_wr;
  int           obs_id;
  logic [N-1:0] acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int from);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0]  exp_rdy;
    logic          exp_wr;
    logic [DW-1:0] exp_d;
    bus.req_valid = valid;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data[i];
    bus.fifo_full = full;
    @(negedge clk);
    exp_rdy = '0;
    if (m_owner >= 0 && !full && !rst) exp_rdy[m_owner] = 1'b1;
    exp_wr = ((exp_rdy & valid) != '0);
    exp_d  = (m_owner >= 0) ? data[m_owner] : '0;
    chk("grant_active", 32'(bus.grant_active), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("grant_id", 32'(bus.grant_id), m_owner);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(exp_wr));
    chk("fifo_data_in", 32'(bus.fifo_data_in), 32'(exp_d));
    obs_wr = bus.fifo_wr_en;
    obs_id = int'(bus.grant_id);
    acc    = exp_rdy & valid;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      m_owner = pick(m_last); m_cnt = 0;
    end else begin
      if (exp_wr) m_cnt++;
      if (!valid[m_owner] || m_cnt == MB) begin
        m_last  = m_owner;
        m_owner = pick(m_last);
        m_cnt   = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) data[i] = DW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; full = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    int wrote;
    n_vec = 0; n_err = 0;
    m_owner = -1; m_cnt = 0; m_last = N - 1;
    rst = 1'b1; valid = '1; full = 1'b0;
    for (int i = 0; i < N; i++) data[i] = DW'($urandom);
    bus.req_valid = valid;
    bus.fifo_full = full;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data[i];
    @(posedge clk);
    #1;

    // Reset held with all requesters valid, then 16 back-to-back rotated burst writes.
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("rot_wr", 32'(obs_wr), 1);
      chk("rot_id", obs_id, i / MB);
    end

    // Early release: req 2 drops after two words while req 3 waits.
    do_reset();
    valid = 4'b0100;
    cycle();
    cycle();
    valid[3] = 1'b1;
    cycle();
    valid[2] = 1'b0;
    cycle();
    chk("early_gid", 32'(bus.grant_id), 3);
    repeat (6) cycle();

    // Full stall mid-burst for req 1.
    do_reset();
    valid = 4'b0010;
    cycle();
    cycle();
    wrote = int'(obs_wr);
    full = 1'b1;
    repeat (5) begin
      cycle();
      chk("stall_wr", 32'(obs_wr), 0);
      chk("stall_id", obs_id, 1);
    end
    full = 1'b0;
    for (int g = 0; g < 10 && wrote < MB; g++) begin
      cycle();
      wrote += int'(obs_wr);
    end
    chk("stall_words", wrote, MB);
    repeat (3) cycle();

    // Sole requester 3: ten words with no bubble across regrants.
    do_reset();
    valid = 4'b1000;
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("sole_wr", 32'(obs_wr), 1);
    end

    // Reset during the second word of req 0's burst.
    do_reset();
    valid = 4'b0001;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_wr", 32'(obs_wr), 0);
    chk("rst_active", 32'(bus.grant_active), 0);
    rst = 1'b0;
    valid = '1;
    cycle();
    chk("rst_regrant", 32'(bus.grant_id), 0);

    // Random traffic with legal valid drops, full stalls and sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      full = ($urandom_range(0, 4) == 0);
      for (int j = 0; j < N; j++) begin
        if (!valid[j]) begin
          if ($urandom_range(0, 2) == 0) begin
            valid[j] = 1'b1;
            data[j]  = DW'($urandom);
          end
        end else if (acc[j]) begin
          valid[j] = ($urandom_range(0, 9) < 7);
        end else if ($urandom_range(0, 19) == 0) begin
          valid[j] = 1'b0;
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
